// File: rtl/pe_stream_feeder_pkg.sv
// Shared types for the PE stream feeder.
// FSM states, item kinds and the skid FIFO entry layout.
package pe_feed_pkg;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 12;
    localparam int LANE_W     = 8;
    localparam int FIFO_DEPTH = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FILT,
        S_LINE,
        S_DRAIN
    } state_e;

    typedef enum logic {
        KIND_FILTER,
        KIND_LINE
    } kind_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        kind_e             kind;
        logic [LANE_W-1:0] lane;
        logic              mac;
    } entry_t;

endpackage

// File: rtl/pe_stream_feeder_if.sv
// Buffer read port plus broadcast PE bus.
// The master side is the feeder, the slave side is memory and PE array.
interface pe_feed_if #(
    parameter int N_LANE = 8
);

    logic                           mem_rd_en;
    logic [pe_feed_pkg::ADDR_W-1:0] mem_rd_addr;
    logic [pe_feed_pkg::DATA_W-1:0] mem_rd_data;
    logic [pe_feed_pkg::DATA_W-1:0] pe_data;
    logic [N_LANE-1:0]              shifting_filter;
    logic [N_LANE-1:0]              shifting_line;
    logic [N_LANE-1:0]              mac_enable;
    logic                           line_buffer_reset;

    modport master (
        output mem_rd_en,
        output mem_rd_addr,
        input  mem_rd_data,
        output pe_data,
        output shifting_filter,
        output shifting_line,
        output mac_enable,
        output line_buffer_reset
    );

    modport slave (
        input  mem_rd_en,
        input  mem_rd_addr,
        output mem_rd_data,
        input  pe_data,
        input  shifting_filter,
        input  shifting_line,
        input  mac_enable,
        input  line_buffer_reset
    );

endinterface

// File: rtl/pe_stream_feeder_fifo.sv
// Four-entry skid FIFO between the read port and the output stage.
// Absorbs read latency while the PE bus is held.
module feeder_skid_fifo
    import pe_feed_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       push_i,
    input  entry_t     push_data_i,
    input  logic       pop_i,
    output entry_t     head_o,
    output logic [2:0] count_o
);

    entry_t     mem_q [FIFO_DEPTH];
    logic [1:0] wr_q;
    logic [1:0] rd_q;
    logic [2:0] cnt_q;
    logic       do_push;
    logic       do_pop;

    assign do_pop  = pop_i && (cnt_q != 3'd0);
    assign do_push = push_i && ((cnt_q != 3'(FIFO_DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= push_data_i;
                wr_q        <= wr_q + 2'd1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 2'd1;
            end
            cnt_q <= cnt_q + {2'b0, do_push} - {2'b0, do_pop};
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/pe_stream_feeder.sv
// Reads weights then line data from the buffer and streams them
// onto the PE bus with per-lane strobes and window-valid pulses.
module pe_stream_feeder
    import pe_feed_pkg::*;
#(
    parameter int N_LANE = 8,
    parameter int K      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] cfg_filt_base_i,
    input  logic [ADDR_W-1:0] cfg_line_base_i,
    input  logic [ADDR_W-1:0] cfg_row_length_i,
    input  logic [ADDR_W-1:0] cfg_num_rows_i,
    input  logic              hold_i,
    output logic              busy_o,
    output logic              done_o,
    pe_feed_if.master         bus
);

    localparam int                TAPS      = K * K;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N_LANE - 1);
    localparam logic [LANE_W-1:0] LAST_TAP  = LANE_W'(TAPS - 1);
    localparam logic [ADDR_W-1:0] WIN_EDGE  = ADDR_W'(K - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] line_base_q;
    logic [ADDR_W-1:0] rlen_q;
    logic [ADDR_W-1:0] nrows_q;
    logic [ADDR_W-1:0] row_q;
    logic [ADDR_W-1:0] col_q;
    logic [LANE_W-1:0] lane_q;
    logic [LANE_W-1:0] tap_q;
    logic              rd_vld_q;
    kind_e             tag_kind_q;
    logic [LANE_W-1:0] tag_lane_q;
    logic              tag_mac_q;
    logic              lbr_q;
    logic [DATA_W-1:0] pe_data_q;
    logic [N_LANE-1:0] filt_q;
    logic [N_LANE-1:0] line_q;
    logic [N_LANE-1:0] mac_q;
    logic              mac_pend_q;
    logic              busy_q;
    logic              done_q;

    logic              issue;
    logic              pop;
    logic              last_filt;
    logic              last_line;
    logic              mac_tag;
    logic              drained;
    logic [2:0]        fifo_cnt;
    logic [N_LANE-1:0] head_bit;
    entry_t            head;
    entry_t            push_e;

    // Throttle keeps FIFO plus the read in flight within the 4 slots.
    assign issue = ((state_q == S_FILT) || (state_q == S_LINE)) && !hold_i
                   && ((fifo_cnt + {2'b0, rd_vld_q}) <= 3'd2);
    assign pop   = (fifo_cnt != 3'd0) && !hold_i;

    assign last_filt = (lane_q == LAST_LANE) && (tap_q == LAST_TAP);
    assign last_line = (lane_q == LAST_LANE)
                       && (col_q == rlen_q - 1'b1)
                       && (row_q == nrows_q - 1'b1);
    assign mac_tag   = (lane_q == LAST_LANE)
                       && (row_q >= WIN_EDGE) && (col_q >= WIN_EDGE);
    assign drained   = !rd_vld_q && (fifo_cnt == 3'd0) && !mac_pend_q;
    assign head_bit  = N_LANE'(1) << head.lane;

    always_comb begin
        push_e      = '0;
        push_e.data = bus.mem_rd_data;
        push_e.kind = tag_kind_q;
        push_e.lane = tag_lane_q;
        push_e.mac  = tag_mac_q;
    end

    feeder_skid_fifo u_fifo (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (state_q == S_CLR),
        .push_i      (rd_vld_q),
        .push_data_i (push_e),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (fifo_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            line_base_q <= '0;
            rlen_q      <= '0;
            nrows_q     <= '0;
            row_q       <= '0;
            col_q       <= '0;
            lane_q      <= '0;
            tap_q       <= '0;
            rd_vld_q    <= 1'b0;
            tag_kind_q  <= KIND_FILTER;
            tag_lane_q  <= '0;
            tag_mac_q   <= 1'b0;
            lbr_q       <= 1'b0;
            pe_data_q   <= '0;
            filt_q      <= '0;
            line_q      <= '0;
            mac_q       <= '0;
            mac_pend_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            lbr_q      <= 1'b0;
            done_q     <= 1'b0;
            rd_vld_q   <= issue;
            tag_kind_q <= (state_q == S_LINE) ? KIND_LINE : KIND_FILTER;
            tag_lane_q <= lane_q;
            tag_mac_q  <= (state_q == S_LINE) && mac_tag;

            if (pop) begin
                pe_data_q  <= head.data;
                filt_q     <= (head.kind == KIND_FILTER) ? head_bit : '0;
                line_q     <= (head.kind == KIND_LINE) ? head_bit : '0;
                mac_pend_q <= head.mac;
            end else begin
                filt_q     <= '0;
                line_q     <= '0;
                mac_pend_q <= 1'b0;
            end
            mac_q <= {N_LANE{mac_pend_q}};

            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        addr_q      <= cfg_filt_base_i;
                        line_base_q <= cfg_line_base_i;
                        rlen_q      <= cfg_row_length_i;
                        nrows_q     <= cfg_num_rows_i;
                        lane_q      <= '0;
                        tap_q       <= '0;
                        busy_q      <= 1'b1;
                        lbr_q       <= 1'b1;
                        state_q     <= S_CLR;
                    end
                end
                S_CLR: state_q <= S_FILT;
                S_FILT: begin
                    if (issue) begin
                        if (last_filt) begin
                            addr_q  <= line_base_q;
                            lane_q  <= '0;
                            tap_q   <= '0;
                            row_q   <= '0;
                            col_q   <= '0;
                            state_q <= ((rlen_q == '0) || (nrows_q == '0))
                                       ? S_DRAIN : S_LINE;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                            if (tap_q == LAST_TAP) begin
                                tap_q  <= '0;
                                lane_q <= lane_q + 1'b1;
                            end else begin
                                tap_q <= tap_q + 1'b1;
                            end
                        end
                    end
                end
                S_LINE: begin
                    if (issue) begin
                        addr_q <= addr_q + 1'b1;
                        if (lane_q != LAST_LANE) begin
                            lane_q <= lane_q + 1'b1;
                        end else begin
                            lane_q <= '0;
                            if (col_q != rlen_q - 1'b1) begin
                                col_q <= col_q + 1'b1;
                            end else begin
                                col_q <= '0;
                                row_q <= row_q + 1'b1;
                            end
                        end
                        if (last_line) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drained) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_rd_en         = issue;
    assign bus.mem_rd_addr       = addr_q;
    assign bus.pe_data           = pe_data_q;
    assign bus.shifting_filter   = filt_q;
    assign bus.shifting_line     = line_q;
    assign bus.mac_enable        = mac_q;
    assign bus.line_buffer_reset = lbr_q;
    assign busy_o                = busy_q;
    assign done_o                = done_q;

endmodule

// File: tb/tb_pe_stream_feeder.sv
// Bench for pe_stream_feeder: random jobs and hold patterns
// compared every cycle against a queue model of the item stream.
module tb_pe_stream_feeder;
    import pe_feed_pkg::*;

    localparam int NL = 4;
    localparam int KE = 3;
    localparam int KK = KE * KE;

    typedef struct {
        logic [DATA_W-1:0] data;
        bit                line;
        int                lane;
        bit                mac;
        int                idx;
    } item_t;

    logic              clk    = 1'b0;
    logic              rst    = 1'b1;
    logic              start  = 1'b1;
    logic              hold   = 1'b0;
    logic [ADDR_W-1:0] cfg_fb = '0;
    logic [ADDR_W-1:0] cfg_lb = '0;
    logic [ADDR_W-1:0] cfg_rl = '0;
    logic [ADDR_W-1:0] cfg_nr = '0;
    logic              busy;
    logic              done;

    pe_feed_if #(.N_LANE(NL)) bus ();

    pe_stream_feeder #(.N_LANE(NL), .K(KE)) dut (
        .clk              (clk),
        .rst              (rst),
        .start_i          (start),
        .cfg_filt_base_i  (cfg_fb),
        .cfg_line_base_i  (cfg_lb),
        .cfg_row_length_i (cfg_rl),
        .cfg_num_rows_i   (cfg_nr),
        .hold_i           (hold),
        .busy_o           (busy),
        .done_o           (done),
        .bus              (bus)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [1 << ADDR_W];

    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // reference model state
    item_t exp_q[$];
    int    rda_q[$];
    int    exp_filt, exp_line, exp_mac;
    bit    m_busy = 0;
    bit    mac_exp = 0;
    bit    rst_prev = 1;
    bit    hold_prev = 0;
    bit    first_strobe = 0;
    bit    lat_chk = 0;
    int    rel = 0, cyc = 0, last_act = 0, last_idx = 0;
    int    issued = 0, strobes = 0;
    int    filt_n = 0, line_n = 0, mac_n = 0, done_n = 0;
    int    mac_idx [8];

    task automatic build(input int fb, input int lb, input int rl,
                         input int nr);
        item_t it;
        exp_q.delete();
        rda_q.delete();
        exp_filt = NL * KK;
        exp_line = NL * rl * nr;
        exp_mac  = 0;
        for (int n = 0; n < NL * KK; n++) begin
            it = '{mem[fb + n], 1'b0, n / KK, 1'b0, n};
            exp_q.push_back(it);
            rda_q.push_back(fb + n);
        end
        for (int r = 0; r < nr; r++)
            for (int c = 0; c < rl; c++)
                for (int l = 0; l < NL; l++) begin
                    int m;
                    m = (r * rl + c) * NL + l;
                    it.data = mem[lb + m];
                    it.line = 1'b1;
                    it.lane = l;
                    it.mac  = (l == NL - 1) && (r >= KE - 1) && (c >= KE - 1);
                    it.idx  = m;
                    if (it.mac) exp_mac++;
                    exp_q.push_back(it);
                    rda_q.push_back(lb + m);
                end
    endtask

    always @(negedge clk) begin : mon
        item_t             it;
        logic [NL-1:0]     sf;
        logic [NL-1:0]     sl;
        logic [NL-1:0]     ones;
        sf   = bus.shifting_filter;
        sl   = bus.shifting_line;
        ones = '1;
        cyc++;
        if (rst_prev) begin
            chk("reset_outputs",
                {bus.mem_rd_en, bus.line_buffer_reset, bus.pe_data,
                 sf, sl, bus.mac_enable, busy, done}, '0);
        end else begin
            if (m_busy) rel++;
            chk("busy", busy, m_busy && !done);
            chk("line_buffer_reset", bus.line_buffer_reset,
                m_busy && rel == 1);
            if (m_busy && rel <= 2)
                chk("first_read", bus.mem_rd_en, rel == 2 && !hold);
            if (bus.mem_rd_en) begin
                issued++;
                if (rda_q.size() == 0) chk("unexpected_read", 1, 0);
                else chk("rd_addr", bus.mem_rd_addr, rda_q.pop_front());
            end
            chk("strobe_onehot", ($countones(sf) + $countones(sl)) <= 1, 1);
            if (hold_prev) chk("strobe_after_hold", (sf | sl) != 0, 0);
            chk("mac_enable", bus.mac_enable, mac_exp ? ones : '0);
            if (bus.mac_enable != 0) begin
                if (mac_n < 8) mac_idx[mac_n] = last_idx;
                mac_n++;
                last_act = cyc;
            end
            mac_exp = 0;
            if ((sf | sl) != 0) begin
                strobes++;
                last_act = cyc;
                if (first_strobe && lat_chk) chk("first_strobe_cycle", rel, 5);
                first_strobe = 0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 1, 0);
                end else begin
                    it = exp_q.pop_front();
                    chk("kind", sl != 0, it.line);
                    chk("lane", sf | sl, NL'(1) << it.lane);
                    chk("data", bus.pe_data, it.data);
                    mac_exp  = it.mac;
                    last_idx = it.idx;
                    if (it.line) line_n++;
                    else filt_n++;
                end
            end
            if (m_busy) chk("outstanding_le4", (issued - strobes) <= 4, 1);
            if (done) begin
                chk("done_while_busy", m_busy, 1);
                chk("done_model_empty", exp_q.size(), 0);
                chk("done_cycle", cyc - last_act, 1);
                done_n++;
                m_busy = 0;
            end
            if (start && !m_busy && !rst) begin
                m_busy       = 1;
                rel          = 0;
                first_strobe = 1;
                issued       = 0;
                strobes      = 0;
            end
        end
        if (rst) begin
            exp_q.delete();
            rda_q.delete();
            m_busy  = 0;
            mac_exp = 0;
        end
        rst_prev  = rst;
        hold_prev = hold;
    end

    // mode 0: plain job, 1: start pulsed mid-job, 2: reset mid-LINE
    task automatic run_job(input int fb, input int lb, input int rl,
                           input int nr, input int hold_pct,
                           input int mode);
        int cnt;
        build(fb, lb, rl, nr);
        filt_n  = 0;
        line_n  = 0;
        mac_n   = 0;
        done_n  = 0;
        lat_chk = (hold_pct == 0);
        @(posedge clk); #2;
        start  = 1'b1;
        cfg_fb = ADDR_W'(fb);
        cfg_lb = ADDR_W'(lb);
        cfg_rl = ADDR_W'(rl);
        cfg_nr = ADDR_W'(nr);
        @(posedge clk); #2;
        start  = 1'b0;
        cfg_fb = ADDR_W'($urandom);
        cfg_lb = ADDR_W'($urandom);
        cfg_rl = ADDR_W'($urandom_range(1, 9));
        cfg_nr = ADDR_W'($urandom_range(1, 9));
        cnt = 0;
        while (done_n == 0 && cnt < 3000) begin
            hold = ($urandom_range(99) < hold_pct);
            start = (mode == 1 && cnt == 20);
            if (mode == 2 && line_n >= 10) begin
                hold = 1'b0;
                rst  = 1'b1;
                @(posedge clk); #2;
                rst = 1'b0;
                break;
            end
            @(posedge clk); #2;
            cnt++;
        end
        hold  = 1'b0;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        if (mode == 2) begin
            chk("abort_no_done", done_n, 0);
            chk("abort_idle", busy, 0);
        end else begin
            chk("done_count", done_n, 1);
            chk("filter_count", filt_n, exp_filt);
            chk("line_count", line_n, exp_line);
            chk("mac_count", mac_n, exp_mac);
            chk("model_drained", exp_q.size() + rda_q.size(), 0);
        end
    endtask

    initial begin
        for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = DATA_W'($urandom);
        repeat (3) @(posedge clk);
        #2;
        rst   = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;

        run_job(100, 500, 4, 3, 0, 0);
        chk("nom_filters", filt_n, 36);
        chk("nom_lines", line_n, 48);
        chk("nom_macs", mac_n, 2);
        chk("nom_mac0_after_m", mac_idx[0], 43);
        chk("nom_mac1_after_m", mac_idx[1], 47);

        run_job(100, 500, 4, 3, 50, 0);
        chk("hold_macs", mac_n, 2);

        run_job(300, 900, 4, 0, 0, 0);
        chk("empty_lines", line_n, 0);
        chk("empty_macs", mac_n, 0);

        run_job(40, 1200, 2, 5, 30, 0);
        chk("undersized_macs", mac_n, 0);

        run_job(100, 500, 4, 3, 0, 2);
        run_job(100, 500, 4, 3, 0, 0);
        chk("replay_macs", mac_n, 2);

        run_job(200, 1500, 5, 4, 0, 1);

        for (int j = 0; j < 3; j++)
            run_job($urandom_range(0, 1000), $urandom_range(1100, 3000),
                    $urandom_range(1, 6), $urandom_range(1, 5),
                    $urandom_range(0, 60), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
